// File: rtl/vol_ctrl.sv
// Front-panel volume controller: syncs and debounces up/down buttons and steps a saturating attenuation level.
// Optional auto-repeat while a button is held is built when VOL_AUTOREPEAT_EN is defined.
module vol_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000,
  parameter logic [4:0]  MAX_LEVEL       = 5'd8,
  parameter logic [4:0]  RESET_LEVEL     = 5'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [4:0] vol_level,
  output logic       vol_changed
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMER_W = 24;
  localparam int unsigned LVL_W   = 5;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  // Index 0 = up, index 1 = down
  logic [1:0]       sync1_q, sync2_q, deb_q, deb_d1_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       rise_c;

  state_t state_q, state_d;
  logic   dir_up_q, dir_up_d;
  logic   step_c;
  logic   active_c, other_c;

  // Two-flop synchroniser plus per-button stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      deb_q    <= 2'b00;
      deb_d1_q <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= {btn_down, btn_up};
      sync2_q  <= sync1_q;
      deb_d1_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign rise_c   = deb_q & ~deb_d1_q;
  assign active_c = dir_up_q ? deb_q[0] : deb_q[1];
  assign other_c  = dir_up_q ? deb_q[1] : deb_q[0];

`ifdef VOL_AUTOREPEAT_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
`else
  logic unused_repeat_c;
  assign unused_repeat_c = ^{REPEAT_DELAY, REPEAT_PERIOD, TIMER_W};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dir_up_q <= 1'b0;
`ifdef VOL_AUTOREPEAT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
`ifdef VOL_AUTOREPEAT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  // Step FSM: a fresh rise of exactly one button steps; the other button or release aborts
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    step_c   = 1'b0;
`ifdef VOL_AUTOREPEAT_EN
    timer_d  = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rise_c[0] && !deb_q[1]) begin
          step_c   = 1'b1;
          dir_up_d = 1'b1;
          state_d  = S_HOLD;
`ifdef VOL_AUTOREPEAT_EN
          timer_d  = REPEAT_DELAY;
`endif
        end else if (rise_c[1] && !deb_q[0]) begin
          step_c   = 1'b1;
          dir_up_d = 1'b0;
          state_d  = S_HOLD;
`ifdef VOL_AUTOREPEAT_EN
          timer_d  = REPEAT_DELAY;
`endif
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!active_c || other_c) begin
          state_d = S_IDLE;
        end else begin
`ifdef VOL_AUTOREPEAT_EN
          if (timer_q == '0) begin
            step_c  = 1'b1;
            timer_d = REPEAT_PERIOD;
            state_d = S_REPEAT;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating level update; a capped step leaves both outputs quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_level   <= RESET_LEVEL;
      vol_changed <= 1'b0;
    end else begin
      vol_changed <= 1'b0;
      if (step_c) begin
        if (dir_up_d) begin
          if (vol_level != '0) begin
            vol_level   <= vol_level - LVL_W'(1);
            vol_changed <= 1'b1;
          end
        end else if (vol_level < MAX_LEVEL) begin
          vol_level   <= vol_level + LVL_W'(1);
          vol_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vol_ctrl.sv
// Directed bench for vol_ctrl with a scoreboard of expected levels checked on each vol_changed pulse.
module tb_vol_ctrl;

  localparam int DB      = 4;
  localparam int RD      = 20;
  localparam int RP      = 8;
  localparam int MAXL    = 8;
  localparam int RSTL    = 4;
  localparam int FIRST   = 3 + DB;
  localparam int SECOND  = FIRST + RD + 1;
  localparam int PERIOD  = RP + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [4:0] vol_level;
  logic       vol_changed;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_lvl = RSTL;
  int pulses_before;
  logic [4:0] exp_q [$];

  vol_ctrl #(
    .DEBOUNCE_CYCLES(16'(DB)),
    .REPEAT_DELAY   (24'(RD)),
    .REPEAT_PERIOD  (24'(RP)),
    .MAX_LEVEL      (5'(MAXL)),
    .RESET_LEVEL    (5'(RSTL))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .vol_level  (vol_level),
    .vol_changed(vol_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pulse must match the next expected level
  always @(negedge clk) begin
    if (rst_n && vol_changed === 1'b1) begin
      pulses++;
      chk("pulse_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("pulse_level", 32'(vol_level), 32'(exp_q.pop_front()));
    end
  end

  function automatic bit is_step(input int e);
    if (e == FIRST) return 1'b1;
`ifdef VOL_AUTOREPEAT_EN
    if (e >= SECOND && ((e - SECOND) % PERIOD) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One button held from just before edge 1; level and pulse checked every edge
  task automatic hold_run(input bit up, input int n);
    bit chg;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      chg = 1'b0;
      if (is_step(e)) begin
        if (up && exp_lvl > 0) begin
          exp_lvl--;
          chg = 1'b1;
        end else if (!up && exp_lvl < MAXL) begin
          exp_lvl++;
          chg = 1'b1;
        end
        if (chg) exp_q.push_back(5'(exp_lvl));
      end
      chk("hold_level", 32'(vol_level), 32'(exp_lvl));
      chk("hold_changed", 32'(vol_changed), 32'(chg));
    end
  endtask

  task automatic press(input bit up, input int hold);
    @(negedge clk);
    if (up) btn_up = 1'b1; else btn_down = 1'b1;
    hold_run(up, hold);
    @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    idle(12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    chk("reset_level", 32'(vol_level), RSTL);
    chk("reset_changed", 32'(vol_changed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("post_reset_level", 32'(vol_level), RSTL);

    // Single clean down press held 10 cycles
    press(1'b0, 10);
    chk("single_down", 32'(vol_level), 5);
    press(1'b1, 8);
    chk("back_to_4", 32'(vol_level), 4);

    // Sub-debounce glitches on up
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_up = 1'b1;
      @(negedge clk);
      @(negedge clk);
      btn_up = 1'b0;
      @(negedge clk);
    end
    idle(12);
    chk("glitch_level", 32'(vol_level), 4);

    // Ten up presses saturate at 0
    pulses_before = pulses;
    for (int i = 0; i < 10; i++) press(1'b1, 8);
    chk("up_sat_level", 32'(vol_level), 0);
    chk("up_sat_pulses", 32'(pulses - pulses_before), 4);

    // Back to 4, then long down hold
    for (int i = 0; i < 4; i++) press(1'b0, 8);
    chk("restore_4", 32'(vol_level), 4);
    press(1'b0, 60);
`ifdef VOL_AUTOREPEAT_EN
    chk("long_hold", 32'(vol_level), 8);
`else
    chk("long_hold", 32'(vol_level), 5);
`endif
    while (exp_lvl != 4) press(1'b1, 8);
    chk("restore_4b", 32'(vol_level), 4);

    // Both buttons raised together: no step
    pulses_before = pulses;
    @(negedge clk);
    btn_up = 1'b1;
    btn_down = 1'b1;
    idle(20);
    @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    idle(12);
    chk("both_level", 32'(vol_level), 4);
    chk("both_pulses", 32'(pulses - pulses_before), 0);

    // Down held, then up raised: abort, no further step on either button
    @(negedge clk);
    btn_down = 1'b1;
    hold_run(1'b0, 10);
    @(negedge clk);
    btn_up = 1'b1;
    idle(30);
    @(negedge clk);
    btn_down = 1'b0;
    idle(15);
    @(negedge clk);
    btn_up = 1'b0;
    idle(12);
    chk("opposite_level", 32'(vol_level), 5);
    press(1'b1, 8);

    // Reset in the middle of a held press
    @(negedge clk);
    btn_down = 1'b1;
    hold_run(1'b0, 30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midhold_rst_level", 32'(vol_level), RSTL);
    chk("midhold_rst_changed", 32'(vol_changed), 0);
    exp_lvl = RSTL;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_run(1'b0, 10);
    @(negedge clk);
    btn_down = 1'b0;
    idle(12);
    chk("post_rst_level", 32'(vol_level), 5);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vol_ctrl.md
# vol_ctrl

Front-panel volume controller that turns raw up/down push buttons into the 5-bit `vol_level` attenuation code consumed by the volume bar-LED display and the decoder volume path. It synchronises and debounces both buttons, and steps the level once per press with saturation. Optionally it auto-repeats while a button is held. Convention: `vol_level` 0 = loudest (all 8 LEDs lit), `MAX_LEVEL` = quietest.

## Interface
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive stable cycles required before a button change is accepted (≥2).
- `REPEAT_DELAY`, 24'd5000000: hold time, in cycles after the first step, before auto-repeat starts.
- `REPEAT_PERIOD`, 24'd2500000: cycles between auto-repeat steps.
- `MAX_LEVEL`, 5'd8: largest (quietest) `vol_level`.
- `RESET_LEVEL`, 5'd4: `vol_level` after reset (≤ `MAX_LEVEL`).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`  in  1  raw, asynchronous, active-high "louder" button.
- `btn_down`  in  1  raw, asynchronous, active-high "quieter" button.
- `vol_level`  out  5  current attenuation level, 0..`MAX_LEVEL`.
- `vol_changed`  out  1  one-cycle pulse on every edge where `vol_level` changes value.

## Operation
- Synchroniser: each button passes through 2 flops, giving `up_s` and `down_s`.
- Debounce, per button: a counter runs while the sync value ≠ the debounced value and clears to 0 when they are equal. When the counter reaches `DEBOUNCE_CYCLES`-1 with the mismatch still present, the debounced value takes the sync value and the counter clears.
- Step FSM, one for both buttons. States:
  - IDLE: debounced up XOR down rises → issue one step, load the repeat timer with `REPEAT_DELAY`, go to HOLD.
  - HOLD: timer decrements each cycle. At 0, issue a step, reload with `REPEAT_PERIOD`, go to REPEAT.
  - REPEAT: timer decrements each cycle. At 0, issue a step and reload with `REPEAT_PERIOD`.
  - HOLD/REPEAT → IDLE when the active button's debounced value falls, or when the other button's debounced value rises.
- Step, up: `vol_level` ← `vol_level`-1 unless already 0.
- Step, down: `vol_level` ← `vol_level`+1 unless already `MAX_LEVEL`.
- Saturated step: `vol_level` unchanged and `vol_changed` stays 0.
- Both buttons debounced-high in the same cycle: no step. FSM stays in, or returns to, IDLE. A step occurs only from a fresh rise of exactly one button while the other is low.
- Arithmetic is 5-bit unsigned. `vol_level` never leaves 0..`MAX_LEVEL`, and no wrap-around occurs.

## Timing
- Reset values: `vol_level` = `RESET_LEVEL`, `vol_changed` = 0, FSM = IDLE, debounced values = 0, all counters = 0, sync flops = 0.
- Press latency: raw button high and stable before edge 1. `up_s` is high after edge 2. The debounced value is high after edge 2+`DEBOUNCE_CYCLES`. `vol_level` and `vol_changed` update on edge 3+`DEBOUNCE_CYCLES`.
- `vol_changed` is asserted in exactly the cycle following the `vol_level` update edge and is low the next cycle unless another step occurs.
- Auto-repeat: the second step lands `REPEAT_DELAY`+1 edges after the first. Later steps are `REPEAT_PERIOD`+1 edges apart.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles (post-sync) produce no change.
- When `rst_n` is asserted mid-hold or mid-debounce, all state returns to reset values immediately. After release, a still-held button needs a full debounce before it is recognised as a new press.

## Configuration
- `VOL_AUTOREPEAT_EN` defined: HOLD/REPEAT auto-repeat as described.
- `VOL_AUTOREPEAT_EN` undefined:
  - The repeat timer is not built.
  - HOLD waits only for the release or opposite-rise exit.
  - Each press gives exactly one step however long it is held.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
Sim parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `MAX_LEVEL`=8, `RESET_LEVEL`=4.
- Reset, then a single clean `btn_down` press held 10 cycles → `vol_level` 4→5 on edge 7 after press, one `vol_changed` pulse, no further change.
- `btn_up` bursts of 2-cycle pulses separated by 1-cycle gaps for 30 cycles → `vol_level` stays 4 and `vol_changed` never asserts.
- Ten separate `btn_up` presses from level 4 → level reaches 0 after 4 presses, then stays 0. Exactly 4 `vol_changed` pulses.
- `btn_down` held 60 cycles with the macro defined → steps at edges 7, 28, 37, 46, 55: level 4→9 is capped at 8. Last pulse on 8, no pulse for the capped step. Macro undefined → single step to 5.
- `btn_up` and `btn_down` raised on the same cycle and held → no step. While `btn_down` is held, raise `btn_up` → FSM to IDLE and no step.
- `rst_n` pulsed low during auto-repeat with the button still held → `vol_level`=4 and `vol_changed`=0 immediately. First post-reset step occurs 3+`DEBOUNCE_CYCLES` edges after `rst_n` rises.
